// File: rtl/lock_entry_sequencer.sv
// lock_entry_sequencer: keypad entry, code check, lockout and code-change sequencing for a six-digit lock
module lock_entry_sequencer #(
    parameter int MAX_TRIES      = 3,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    input  logic [23:0] stored_code_i,
    output logic [23:0] entry_o,
    output logic [2:0]  digit_cnt_o,
    output logic        code_we_o,
    output logic        unlock_o,
    output logic        alarm_o,
    output logic        err_o,
    output logic [2:0]  fail_cnt_o,
    output logic [2:0]  state_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ENTRY   = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] OPEN    = 3'd3;
    localparam logic [2:0] LOCKOUT = 3'd4;
    localparam logic [2:0] SET     = 3'd5;
    localparam logic [2:0] COMMIT  = 3'd6;
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]    state_q, state_d;
    logic [23:0]   entry_q, entry_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    fail_q, fail_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic dig, ent, can, setk, room, match;
    logic [2:0]  fail_inc;
    logic [23:0] shifted;

    assign dig      = key_valid_i && key_code_i <= 4'd9;
    assign ent      = key_valid_i && key_code_i == 4'hA;
    assign can      = key_valid_i && key_code_i == 4'hB;
    assign setk     = key_valid_i && key_code_i == 4'hC;
    assign room     = cnt_q < 3'd6;
    assign match    = cnt_q == 3'd6 && entry_q == stored_code_i;
    assign fail_inc = fail_q + 3'd1;
    assign shifted  = {entry_q[19:0], key_code_i};

    // State and datapath registers, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next state: key handling per state, timers count down and saturate at zero
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        err_d   = 1'b0;
        tmr_d   = (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
        case (state_q)
            IDLE, ENTRY: begin
                if (dig && room) begin
                    entry_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = ENTRY;
                end else if (ent) begin
                    state_d = CHECK;
                end else if (can) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (match) begin
                    fail_d  = '0;
                    state_d = OPEN;
                    tmr_d   = TW'(UNLOCK_CYCLES);
                end else begin
                    fail_d  = fail_inc;
                    err_d   = 1'b1;
                    state_d = (fail_inc == 3'(MAX_TRIES)) ? LOCKOUT : IDLE;
                    tmr_d   = (fail_inc == 3'(MAX_TRIES)) ? TW'(LOCKOUT_CYCLES) : tmr_d;
                end
            end
            OPEN: begin
                if (setk) begin
                    state_d = SET;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (can || tmr_q <= TW'(1)) begin
                    state_d = IDLE;
                end
            end
            SET: begin
                if (dig && room) begin
                    entry_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                end else if (ent && cnt_q == 3'd6) begin
                    state_d = COMMIT;
                end else if (ent || can) begin
                    err_d   = ent;
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_q <= TW'(1)) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                entry_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: registers directly, state-decoded flags
    always_comb begin
        entry_o     = entry_q;
        digit_cnt_o = cnt_q;
        fail_cnt_o  = fail_q;
        err_o       = err_q;
        state_o     = state_q;
        unlock_o    = state_q == OPEN;
        alarm_o     = state_q == LOCKOUT;
        code_we_o   = state_q == COMMIT;
    end
endmodule
